inst_fetch_unit: RTL and testbench
==================================

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with the ports listed below (clock and reset first).
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 freeze  in  1  downstream stall; the current output instruction is not consumed this cycle.
REQ-005 branchTaken  in  1  redirect request from execute; squashes all fetched instructions.
REQ-006 branchAddr  in  32  redirect target; bits [1:0] are ignored and treated as 0.
REQ-007 imemReq  out  1  instruction-memory request, level-sensitive.
REQ-008 imemAddr  out  32  word-aligned fetch address.
REQ-009 imemAck  in  1  one-cycle response strobe; imemData is valid in the same cycle.
REQ-010 imemData  in  32  returned instruction word.
REQ-011 instruction  out  32  instruction word presented to the fetch/decode register.
REQ-012 pc  out  32  address of the presented instruction + 4.
REQ-013 instValid  out  1  instruction/pc hold a live instruction.

Function
REQ-014 The block SHALL keep a fetch address register fa, a 1-entry skid buffer (data, pc, valid), an output register (instruction, pc, instValid), and a state machine with states REQ, HOLD and DROP.
REQ-015 imemReq SHALL be 1 exactly in states REQ and DROP, and imemAddr SHALL equal the address of the outstanding request.
REQ-016 Once imemReq is asserted, imemAddr SHALL stay stable until the cycle in which imemAck=1; an ack may arrive in the same cycle as the request (zero wait) or any number of cycles later.
REQ-017 Consume SHALL be defined as instValid & ~freeze; the output is consumed at that clock edge.
REQ-018 On an ack in REQ without branchTaken, the word SHALL go to the output register if (~instValid | consume) and the skid buffer is empty, and to the skid buffer otherwise.
- The captured pc SHALL be fa+4.
- fa SHALL advance to fa+4, wrapping modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-019 On consume with the skid buffer full, the skid entry SHALL move to the output register and the skid buffer SHALL empty in the same edge.
REQ-020 On consume with no skid entry and no ack, instValid SHALL drop to 0.
REQ-021 REQ SHALL go to HOLD when the skid buffer becomes full; HOLD SHALL return to REQ on the edge at which the skid buffer empties.
REQ-022 While freeze=1 and branchTaken=0, instruction, pc and instValid SHALL hold their values.
REQ-023 branchTaken SHALL have the highest priority, overriding freeze and any ack: instValid<=0, skid valid<=0, fa<=branchAddr.
REQ-024 branchTaken in REQ with imemAck=0 SHALL enter DROP.
- DROP SHALL hold imemReq=1 at the old address.
- DROP SHALL discard the returning word.
- DROP SHALL go to REQ after the ack, and the next request SHALL use branchAddr.
REQ-025 branchTaken with imemAck=1 in the same cycle SHALL discard the data and go directly to REQ with fa=branchAddr.
REQ-026 branchTaken in HOLD SHALL go to REQ with fa=branchAddr.
REQ-027 branchTaken in DROP SHALL update fa to the newest branchAddr and remain in DROP until the ack.
REQ-028 Sustained throughput SHALL be one instruction per cycle with zero-wait memory and freeze=0.

Reset
REQ-029 While rst=1, the block SHALL hold state=REQ, fa=0, skid valid=0, instruction=0, pc=0, instValid=0.
REQ-030 After rst falls, the first request SHALL be imemReq=1, imemAddr=0x00000000.
REQ-031 Reset asserted with a request outstanding SHALL abandon that request with no DROP; an ack arriving during reset SHALL be ignored.

Verification
REQ-032 Zero-wait stream: reset, freeze=0, imemAck always 1 -> imemAddr 0,4,8,...; outputs pc=4,8,12 with instValid=1 every cycle from the second cycle after reset.
REQ-033 Stall with skid: two words captured while freeze=1 -> second word held in skid, state HOLD, imemReq=0; freeze released -> words presented in order on consecutive cycles, then REQ resumes at the next address.
REQ-034 Branch with request outstanding: imemAddr=0x10 pending, branchTaken with branchAddr=0x200 -> instValid=0, DROP; ack for 0x10 discarded, next imemAddr=0x200, and pc=0x204 is presented.
REQ-035 Branch coincident with ack and freeze=1: data discarded, instValid=0, next imemAddr=branchAddr.
REQ-036 Wrap-around: branchAddr=0xFFFFFFFC -> presented pc=0x00000000 and next imemAddr=0x00000000.
REQ-037 Reset during HOLD with instValid=1 and skid full -> all outputs 0 immediately (asynchronous); after release, imemAddr=0.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: one outstanding memory request, a 1-entry skid
// buffer behind the output register, and squash-on-branch with a DROP state.
module inst_fetch_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branchTaken,
   input  logic [31:0] branchAddr,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemAck,
   input  logic [31:0] imemData,
   output logic [31:0] instruction,
   output logic [31:0] pc,
   output logic        instValid
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_HOLD = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t      state, state_next;
   logic [31:0] fa, fa_inc, drop_addr, branch_target;
   logic [31:0] skid_data, skid_pc;
   logic        skid_valid;
   logic        consume, accept, out_free, load_out, load_skid, skid_pop;

   assign branch_target = {branchAddr[31:2], 2'b00};
   assign fa_inc        = fa + 32'd4;
   assign consume       = instValid & ~freeze;
   assign accept        = (state == S_REQ) & imemAck & ~branchTaken;
   assign out_free      = (~instValid | consume) & ~skid_valid;
   assign load_out      = accept & out_free;
   assign load_skid     = accept & ~out_free;
   assign skid_pop      = consume & skid_valid;

   // DROP keeps presenting the squashed request's address until its ack returns.
   assign imemReq  = (state != S_HOLD);
   assign imemAddr = (state == S_DROP) ? drop_addr : fa;

   always_comb begin
      // NOTE: default assigned first so every path drives state_next (no latch).
      state_next = state;
      case (state)
         S_REQ: begin
            if (branchTaken)    state_next = imemAck ? S_REQ : S_DROP;
            else if (load_skid) state_next = S_HOLD;
         end
         S_HOLD: if (branchTaken || skid_pop) state_next = S_REQ;
         S_DROP: if (imemAck) state_next = S_REQ;
         default: state_next = S_REQ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // sample pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_REQ;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fa        <= 32'd0;
         drop_addr <= 32'd0;
      end else if (branchTaken) begin
         fa <= branch_target;
         if (state == S_REQ && !imemAck) drop_addr <= fa;
      end else if (accept) begin
         fa <= fa_inc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              skid_valid <= 1'b0;
      else if (branchTaken) skid_valid <= 1'b0;
      else                  skid_valid <= load_skid | (skid_valid & ~consume);
   end

   // NOTE: skid payload has no reset; skid_valid alone qualifies it.
   always_ff @(posedge clk) begin
      if (load_skid) begin
         skid_data <= imemData;
         skid_pc   <= fa_inc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instruction <= 32'd0;
         pc          <= 32'd0;
         instValid   <= 1'b0;
      end else if (branchTaken) begin
         instValid <= 1'b0;
      end else if (skid_pop) begin
         instruction <= skid_data;
         pc          <= skid_pc;
         instValid   <= 1'b1;
      end else if (load_out) begin
         instruction <= imemData;
         pc          <= fa_inc;
         instValid   <= 1'b1;
      end else if (consume) begin
         instValid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: a FIFO-level reference model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze, branchTaken, imemAck;
   logic [31:0] branchAddr, imemData;
   logic        imemReq, instValid;
   logic [31:0] imemAddr, instruction, pc;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   inst_fetch_unit dut (
      .clk        (clk),
      .rst        (rst),
      .freeze     (freeze),
      .branchTaken(branchTaken),
      .branchAddr (branchAddr),
      .imemReq    (imemReq),
      .imemAddr   (imemAddr),
      .imemAck    (imemAck),
      .imemData   (imemData),
      .instruction(instruction),
      .pc         (pc),
      .instValid  (instValid)
   );

   always #5 clk = ~clk;

   // Reference model: fetched-but-unconsumed words form an in-order queue of
   // at most two; the head is what the output shows.
   typedef struct packed {
      logic [31:0] data;
      logic [31:0] pc;
   } ent_t;

   ent_t        m_q[$];
   logic [31:0] m_fa;
   logic [31:0] m_drop_addr;
   bit          m_dropping;

   function automatic bit exp_req();
      return m_dropping || (m_q.size() < 2);
   endfunction

   function automatic logic [31:0] exp_addr();
      return m_dropping ? m_drop_addr : m_fa;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_fa        = 32'd0;
      m_drop_addr = 32'd0;
      m_dropping  = 1'b0;
   endtask

   task automatic model_edge();
      bit req;
      req = exp_req();
      if (branchTaken) begin
         if (m_dropping) begin
            if (imemAck) m_dropping = 1'b0;
         end else if (req && !imemAck) begin
            m_dropping  = 1'b1;
            m_drop_addr = m_fa;
         end
         m_q.delete();
         m_fa = branchAddr & 32'hFFFF_FFFC;
      end else if (m_dropping) begin
         if (imemAck) m_dropping = 1'b0;
      end else begin
         if (m_q.size() > 0 && !freeze) void'(m_q.pop_front());
         if (req && imemAck) begin
            m_q.push_back({imemData, m_fa + 32'd4});
            m_fa = m_fa + 32'd4;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   initial forever begin
      @(negedge clk);
      if (cmp_en && !rst) begin
         check("model_instValid", {31'd0, instValid}, {31'd0, m_q.size() > 0});
         check("model_imemReq", {31'd0, imemReq}, {31'd0, exp_req()});
         if (m_q.size() > 0) begin
            check("model_instruction", instruction, m_q[0].data);
            check("model_pc", pc, m_q[0].pc);
         end
         if (exp_req()) check("model_imemAddr", imemAddr, exp_addr());
      end
   end

   task automatic step(input bit f, input bit a, input bit b, input logic [31:0] ba);
      freeze      = f;
      imemAck     = a;
      branchTaken = b;
      branchAddr  = ba;
      imemData    = $urandom;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      freeze      = 1'b0;
      imemAck     = 1'b0;
      branchTaken = 1'b0;
      branchAddr  = 32'd0;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   logic [39:0] fpat = 40'b0011_0110_0001_1100_0111_0000_1101_1000_0010_0110;
   logic [39:0] apat = 40'b1101_1011_1110_0101_1011_1101_0111_1001_1111_1011;

   initial begin
      rst = 1'b1; freeze = 1'b0; imemAck = 1'b0; branchTaken = 1'b0;
      branchAddr = 32'd0; imemData = 32'd0;
      model_reset();
      #12;
      check("rst_imemReq", {31'd0, imemReq}, 32'd1);
      check("rst_imemAddr", imemAddr, 32'd0);
      check("rst_instValid", {31'd0, instValid}, 32'd0);
      check("rst_pc", pc, 32'd0);
      check("rst_instruction", instruction, 32'd0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      cmp_en = 1'b1;

      // Zero-wait stream: one instruction per cycle.
      for (int k = 1; k <= 6; k++) begin
         step(1'b0, 1'b1, 1'b0, 32'd0);
         check("stream_pc", pc, 32'(4 * k));
         check("stream_valid", {31'd0, instValid}, 32'd1);
         check("stream_addr", imemAddr, 32'(4 * k));
      end

      // Stall: second word parks in the skid buffer, request drops.
      do_reset();
      step(1'b1, 1'b1, 1'b0, 32'd0);
      check("stall_first_pc", pc, 32'd4);
      step(1'b1, 1'b1, 1'b0, 32'd0);
      check("stall_hold_req", {31'd0, imemReq}, 32'd0);
      check("stall_hold_pc", pc, 32'd4);
      step(1'b1, 1'b1, 1'b0, 32'd0);
      check("stall_still_pc", pc, 32'd4);
      check("stall_still_req", {31'd0, imemReq}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'd0);
      check("stall_skid_pc", pc, 32'd8);
      check("stall_resume_req", {31'd0, imemReq}, 32'd1);
      check("stall_resume_addr", imemAddr, 32'd8);
      step(1'b0, 1'b0, 1'b0, 32'd0);
      check("stall_drain_valid", {31'd0, instValid}, 32'd0);
      step(1'b0, 1'b1, 1'b0, 32'd0);
      check("stall_next_pc", pc, 32'd12);

      // Branch with a request outstanding at 0x10.
      do_reset();
      for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 32'd0);
      step(1'b0, 1'b0, 1'b1, 32'h200);
      check("drop_valid", {31'd0, instValid}, 32'd0);
      check("drop_req", {31'd0, imemReq}, 32'd1);
      check("drop_addr", imemAddr, 32'h10);
      step(1'b0, 1'b0, 1'b0, 32'd0);
      check("drop_wait_addr", imemAddr, 32'h10);
      step(1'b0, 1'b1, 1'b0, 32'd0);
      check("drop_discard_valid", {31'd0, instValid}, 32'd0);
      check("drop_next_addr", imemAddr, 32'h200);
      step(1'b0, 1'b1, 1'b0, 32'd0);
      check("drop_target_pc", pc, 32'h204);
      check("drop_target_valid", {31'd0, instValid}, 32'd1);

      // Branch coincident with ack and freeze; low address bits ignored.
      step(1'b1, 1'b1, 1'b1, 32'h303);
      check("coinc_valid", {31'd0, instValid}, 32'd0);
      check("coinc_addr", imemAddr, 32'h300);

      // Wrap-around at the top of the address space.
      step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
      check("wrap_fetch_addr", imemAddr, 32'hFFFF_FFFC);
      step(1'b0, 1'b1, 1'b0, 32'd0);
      check("wrap_pc", pc, 32'd0);
      check("wrap_next_addr", imemAddr, 32'd0);

      // Re-branch while in DROP: newest target wins.
      step(1'b0, 1'b0, 1'b1, 32'h400);
      check("rebr_drop_addr", imemAddr, 32'd0);
      step(1'b0, 1'b0, 1'b1, 32'h500);
      check("rebr_still_addr", imemAddr, 32'd0);
      step(1'b0, 1'b1, 1'b0, 32'd0);
      check("rebr_next_addr", imemAddr, 32'h500);
      step(1'b0, 1'b1, 1'b0, 32'd0);
      check("rebr_pc", pc, 32'h504);

      // Branch while in HOLD.
      step(1'b1, 1'b1, 1'b0, 32'd0);
      check("hold_br_pre_req", {31'd0, imemReq}, 32'd0);
      step(1'b1, 1'b0, 1'b1, 32'h600);
      check("hold_br_valid", {31'd0, instValid}, 32'd0);
      check("hold_br_req", {31'd0, imemReq}, 32'd1);
      check("hold_br_addr", imemAddr, 32'h600);

      // Asynchronous reset in HOLD with skid full; ack during reset ignored.
      step(1'b1, 1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b1, 1'b0, 32'd0);
      check("arst_pre_req", {31'd0, imemReq}, 32'd0);
      check("arst_pre_valid", {31'd0, instValid}, 32'd1);
      rst     = 1'b1;
      imemAck = 1'b1;
      model_reset();
      #1;
      check("arst_valid", {31'd0, instValid}, 32'd0);
      check("arst_pc", pc, 32'd0);
      check("arst_instruction", instruction, 32'd0);
      check("arst_addr", imemAddr, 32'd0);
      check("arst_req", {31'd0, imemReq}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("arst_rel_addr", imemAddr, 32'd0);
      check("arst_rel_valid", {31'd0, instValid}, 32'd0);
      step(1'b0, 1'b1, 1'b0, 32'd0);
      check("arst_first_pc", pc, 32'd4);

      // Mixed freeze/ack pattern with periodic branches, checked by the model.
      for (int i = 0; i < 40; i++)
         step(fpat[i], apat[i], (i % 13) == 12, 32'h1000 + 32'(i * 16) + 32'd3);
      step(1'b0, 1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
